mem_dump_streamer: RTL and testbench
====================================

Name: mem_dump_streamer

Overview:
- Hardware counterpart of the bench's memory loader: after a run, it reads a contiguous address range out of a data_mem instance.
- Emits each byte on a valid/ready byte stream for a host link or checker.
- Sits between data_mem (via the integration mux, like the CPU port) and any byte sink.
- Replaces the testbench-only dump loop with synthesizable logic.

Parameters:
ADDR_W, 12, memory address width (matches data_mem)
DATA_W, 8, memory/stream data width
FIFO_DEPTH, 4, output buffer entries; power of 2, >=2; >=3 needed for 1 byte/cycle

Ports:
clk  input  1  system clock
reset  input  1  synchronous, active-high reset
start  input  1  1-cycle pulse; begins a dump (ignored unless idle)
abort  input  1  1-cycle pulse; cancels dump, flushes buffer
start_addr  input  ADDR_W  first address read (sampled on start)
end_addr  input  ADDR_W  last address read, inclusive (sampled on start)
m_addr  output  ADDR_W  memory read address
m_rd  output  1  memory read strobe
m_en  output  1  memory enable (equals m_rd)
m_rd_data  input  DATA_W  memory read data, valid 1 cycle after m_rd
out_data  output  DATA_W  stream byte
out_valid  output  1  stream byte valid
out_ready  input  1  sink accepts byte
out_last  output  1  marks final byte of dump
busy  output  1  high from accepted start until done/abort
done  output  1  1-cycle completion pulse
err  output  1  1-cycle pulse with done on range error
byte_count  output  ADDR_W+1  bytes transferred in current/last dump

Behaviour:
- Reset (sync, active-high): state IDLE; all outputs 0; m_addr=0; FIFO empty; byte_count=0.
- FSM states:
  - IDLE -> RANGE_ERR on start when start_addr>end_addr.
  - IDLE -> READ on start otherwise.
  - READ -> DRAIN after the read of end_addr issues.
  - DRAIN -> FINISH when the byte with out_last transfers.
  - FINISH -> IDLE next cycle.
  - RANGE_ERR -> IDLE next cycle.
- start accepted at edge T: busy=1 from T+1; byte_count cleared to 0.
- Read issue (READ): m_rd=1 only when (fifo_count + inflight) < FIFO_DEPTH.
  - First m_rd at T+1 with m_addr=start_addr; m_addr increments per issued read.
  - Address counter is ADDR_W+1 bits, so end_addr=all-ones never wraps to 0.
- m_rd_data captured at cycle after m_rd, pushed into FIFO; at most 1 read in flight.
- First out_valid at T+3.
- Stream: out_data/out_valid/out_last driven from FIFO head; transfer = out_valid & out_ready.
  - out_data stable while out_valid & !out_ready.
- out_last asserted with the byte read from end_addr only.
- byte_count increments per transfer; holds after done until next start.
- With out_ready held 1 and FIFO_DEPTH>=3: one byte per cycle, N bytes on T+3..T+N+2.
- done=1 (and busy=0) the cycle after the last transfer.
- RANGE_ERR: done=1 and err=1 for 1 cycle; no m_rd issued; byte_count=0.
- abort (any non-IDLE state): next cycle IDLE, FIFO flushed, out_valid=0, m_rd=0, busy=0, no done; an in-flight return is discarded.
- start and abort in the same cycle: abort wins; start dropped.
- start while busy: ignored.
- reset mid-dump: same as reset; sink sees out_valid fall without out_last.

Decomposition:
- Shared constants header (noobs_defines): ADDR_W, DATA_W, MEM_SPECIAL_BASE=8, FSM state encodings.
- Sub-module mem_dump_fifo: synchronous FIFO with push/pop/flush, count output, first-word-fall-through head.
- Top module holds FSM, address counter, credit/in-flight logic and byte counter.

Test Plan:
1. Mem[8..11]=A0,A1,A2,A3, start_addr=8, end_addr=11, out_ready=1 -> A0..A3 on T+3..T+6; out_last with A3; done at T+7; byte_count=4.
2. Same range, out_ready pattern 1,0,1,0... -> bytes exactly A0..A3 in order, none lost or duplicated; m_rd stalls when FIFO+inflight=4; done 1 cycle after A3 accepted.
3. start_addr=end_addr=0x7FF, mem=5C -> single byte 5C with out_last; byte_count=1.
4. start_addr=0xFFE, end_addr=0xFFF -> exactly 2 reads (0xFFE, 0xFFF), no access to 0x000; done; busy=0.
5. start_addr=0x010, end_addr=0x00F -> done=err=1 at T+1; m_rd never asserted; byte_count=0.
6. Dump 8..2047; abort after 5 transfers -> out_valid=0 and busy=0 next cycle; no done; new start succeeds. Separately, reset mid-dump -> all outputs 0 next cycle.

Source files
------------

// File: rtl/mem_dump_streamer_pkg.sv
// mem_dump_streamer shared constants and types
// Default widths, special memory base and FSM state encodings
package mem_dump_streamer_pkg;

  localparam int DEF_ADDR_W       = 12;
  localparam int DEF_DATA_W       = 8;
  localparam int DEF_FIFO_DEPTH   = 4;
  localparam int MEM_SPECIAL_BASE = 8;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_READ      = 3'd1,
    S_DRAIN     = 3'd2,
    S_FINISH    = 3'd3,
    S_RANGE_ERR = 3'd4
  } state_e;

endpackage

// File: rtl/mem_dump_streamer_fifo.sv
// mem_dump_fifo: output buffer for the dump stream
// Synchronous FIFO, first-word-fall-through head, flush clears it
module mem_dump_fifo #(
  parameter int W     = 9,
  parameter int DEPTH = 4
) (
  input  logic                       clk_i,
  input  logic                       reset_i,
  input  logic                       flush_i,
  input  logic                       push_i,
  input  logic [W-1:0]               push_data_i,
  input  logic                       pop_i,
  output logic [W-1:0]               head_o,
  output logic                       valid_o,
  output logic [$clog2(DEPTH):0]     count_o
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_q;
  logic [AW-1:0] rd_q;
  logic [AW:0]   cnt_q;
  logic          do_push;
  logic          do_pop;

  // Caller never pushes into a full buffer; push during flush is dropped
  assign do_push = push_i && !flush_i;
  assign do_pop  = pop_i && (cnt_q != '0);

  // Storage array, no reset needed
  always_ff @(posedge clk_i) begin
    if (do_push) begin
      mem_q[wr_q] <= push_data_i;
    end
  end

  // Pointers and occupancy
  always_ff @(posedge clk_i) begin
    if (reset_i || flush_i) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (do_push) begin
        wr_q <= wr_q + AW'(1);
      end
      if (do_pop) begin
        rd_q <= rd_q + AW'(1);
      end
      cnt_q <= cnt_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end

  assign head_o  = mem_q[rd_q];
  assign valid_o = (cnt_q != '0);
  assign count_o = cnt_q;

endmodule

// File: rtl/mem_dump_streamer.sv
// mem_dump_streamer: reads an address range out of data_mem
// and streams it as bytes on a valid/ready link with a last marker
module mem_dump_streamer
  import mem_dump_streamer_pkg::*;
#(
  parameter int ADDR_W     = DEF_ADDR_W,
  parameter int DATA_W     = DEF_DATA_W,
  parameter int FIFO_DEPTH = DEF_FIFO_DEPTH
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              abort,
  input  logic [ADDR_W-1:0] start_addr,
  input  logic [ADDR_W-1:0] end_addr,
  output logic [ADDR_W-1:0] m_addr,
  output logic              m_rd,
  output logic              m_en,
  input  logic [DATA_W-1:0] m_rd_data,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_last,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [ADDR_W:0]   byte_count
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  state_e            state_q;
  logic [ADDR_W:0]   addr_q;
  logic [ADDR_W:0]   end_q;
  logic [ADDR_W-1:0] m_addr_q;
  logic              rd_q;
  logic              rd_last_q;
  logic              ret_q;
  logic              ret_last_q;
  logic              busy_q;
  logic              done_q;
  logic              err_q;
  logic [ADDR_W:0]   bcnt_q;

  logic [CW-1:0]     fcnt;
  logic [CW-1:0]     fcnt_d;
  logic              fvalid;
  logic [DATA_W:0]   fhead;
  logic              flush;
  logic              xfer;
  logic              credit;

  assign flush  = abort && (state_q != S_IDLE);
  assign xfer   = fvalid && out_ready;
  // Occupancy after this edge plus the read now on the bus must
  // leave room for the read being considered
  assign fcnt_d = fcnt + CW'(ret_q) - CW'(xfer);
  assign credit = (fcnt_d + CW'(rd_q)) < CW'(FIFO_DEPTH);

  mem_dump_fifo #(
    .W     (DATA_W + 1),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i       (clk),
    .reset_i     (reset),
    .flush_i     (flush),
    .push_i      (ret_q),
    .push_data_i ({ret_last_q, m_rd_data}),
    .pop_i       (xfer),
    .head_o      (fhead),
    .valid_o     (fvalid),
    .count_o     (fcnt)
  );

  // Dump FSM: read issue, return tracking, completion and byte count
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      addr_q     <= '0;
      end_q      <= '0;
      m_addr_q   <= '0;
      rd_q       <= 1'b0;
      rd_last_q  <= 1'b0;
      ret_q      <= 1'b0;
      ret_last_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      bcnt_q     <= '0;
    end else if (flush) begin
      state_q    <= S_IDLE;
      rd_q       <= 1'b0;
      rd_last_q  <= 1'b0;
      ret_q      <= 1'b0;
      ret_last_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      ret_q      <= rd_q;
      ret_last_q <= rd_q && rd_last_q;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      if (xfer) begin
        bcnt_q <= bcnt_q + (ADDR_W+1)'(1);
      end
      unique case (state_q)
        S_IDLE: begin
          if (start && !abort) begin
            bcnt_q <= '0;
            if (start_addr > end_addr) begin
              state_q <= S_RANGE_ERR;
              done_q  <= 1'b1;
              err_q   <= 1'b1;
            end else begin
              state_q   <= S_READ;
              busy_q    <= 1'b1;
              rd_q      <= 1'b1;
              m_addr_q  <= start_addr;
              rd_last_q <= (start_addr == end_addr);
              addr_q    <= {1'b0, start_addr} + (ADDR_W+1)'(1);
              end_q     <= {1'b0, end_addr};
            end
          end
        end
        S_READ: begin
          if (rd_q && rd_last_q) begin
            state_q   <= S_DRAIN;
            rd_q      <= 1'b0;
            rd_last_q <= 1'b0;
          end else if (credit) begin
            rd_q      <= 1'b1;
            m_addr_q  <= addr_q[ADDR_W-1:0];
            rd_last_q <= (addr_q == end_q);
            addr_q    <= addr_q + (ADDR_W+1)'(1);
          end else begin
            rd_q <= 1'b0;
          end
        end
        S_DRAIN: begin
          if (xfer && fhead[DATA_W]) begin
            state_q <= S_FINISH;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end
        end
        S_FINISH: state_q <= S_IDLE;
        S_RANGE_ERR: state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign m_addr     = m_addr_q;
  assign m_rd       = rd_q;
  assign m_en       = rd_q;
  assign out_valid  = fvalid;
  assign out_data   = fvalid ? fhead[DATA_W-1:0] : '0;
  assign out_last   = fvalid && fhead[DATA_W];
  assign busy       = busy_q;
  assign done       = done_q;
  assign err        = err_q;
  assign byte_count = bcnt_q;

endmodule

// File: tb/tb_mem_dump_streamer.sv
// tb_mem_dump_streamer: random dumps against a queue-based model
// of the byte stream, plus fixed literal scenarios
module tb_mem_dump_streamer;
  import mem_dump_streamer_pkg::*;

  localparam int AW = 12;
  localparam int DW = 8;
  localparam int DEPTH = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic          abort;
  logic [AW-1:0] start_addr;
  logic [AW-1:0] end_addr;
  logic [AW-1:0] m_addr;
  logic          m_rd;
  logic          m_en;
  logic [DW-1:0] m_rd_data;
  logic [DW-1:0] out_data;
  logic          out_valid;
  logic          out_ready;
  logic          out_last;
  logic          busy;
  logic          done;
  logic          err;
  logic [AW:0]   byte_count;

  mem_dump_streamer #(
    .ADDR_W     (AW),
    .DATA_W     (DW),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .abort      (abort),
    .start_addr (start_addr),
    .end_addr   (end_addr),
    .m_addr     (m_addr),
    .m_rd       (m_rd),
    .m_en       (m_en),
    .m_rd_data  (m_rd_data),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_last   (out_last),
    .busy       (busy),
    .done       (done),
    .err        (err),
    .byte_count (byte_count)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t",
               nm, act, exp, $time);
    end
  endtask

  // Synchronous memory: data one cycle after the read strobe
  logic [DW-1:0] mem [4096];
  always @(posedge clk) begin
    if (m_rd) m_rd_data <= mem[m_addr];
    else      m_rd_data <= DW'($urandom);
  end

  // Sink ready pattern: 0 always, 1 toggle, 2 random, 3 held low
  int rdy_mode = 0;
  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (rdy_mode)
        0: out_ready = 1'b1;
        1: out_ready = ~out_ready;
        3: out_ready = 1'b0;
        default: out_ready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  // Reference model state
  bit          mon_en = 0;
  bit          zero_next = 0;
  bit          active = 0;
  bit          exp_busy = 0;
  bit          exp_done = 0;
  bit          exp_err = 0;
  bit          full_rate = 0;
  bit          was_active;
  bit          prev_done;
  int          k = 0;
  int          n_bytes = 0;
  int          n_xfer = 0;
  int          n_reads = 0;
  int          max_out = 0;
  int          first_k = -1;
  int          last_k = -1;
  int          done_k = -1;
  int          err_k = -1;
  logic [AW:0] rd_next;
  logic [AW:0] bc;
  logic [DW-1:0] exp_q [$];
  logic [DW-1:0] got_q [$];

  // Compare DUT outputs with the model on every falling edge
  always @(negedge clk) begin
    if (!mon_en) begin
      if (reset) begin
        mon_en = 1;
        zero_next = 1;
      end
    end else begin
      k++;
      if (zero_next) begin
        zero_next = 0;
        chk("rst_m_rd", 32'(m_rd), 0);
        chk("rst_m_en", 32'(m_en), 0);
        chk("rst_m_addr", 32'(m_addr), 0);
        chk("rst_out_valid", 32'(out_valid), 0);
        chk("rst_out_data", 32'(out_data), 0);
        chk("rst_out_last", 32'(out_last), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_err", 32'(err), 0);
        chk("rst_byte_count", 32'(byte_count), 0);
      end else begin
        chk("busy", 32'(busy), 32'(exp_busy));
        chk("done", 32'(done), 32'(exp_done));
        chk("err", 32'(err), 32'(exp_err));
        chk("byte_count", 32'(byte_count), 32'(bc));
        chk("m_en", 32'(m_en), 32'(m_rd));
        if (done === 1'b1) done_k = k;
        if (err === 1'b1) err_k = k;
        if (!active) begin
          chk("idle_m_rd", 32'(m_rd), 0);
          chk("idle_out_valid", 32'(out_valid), 0);
        end else begin
          if (m_rd) begin
            chk("rd_in_range", 32'(n_reads < n_bytes), 1);
            chk("m_addr", 32'(m_addr), 32'(rd_next[AW-1:0]));
            chk("credit", 32'((n_reads - n_xfer) < DEPTH), 1);
            n_reads++;
            rd_next++;
            if (n_reads - n_xfer > max_out)
              max_out = n_reads - n_xfer;
          end
          if (full_rate)
            chk("valid_slot", 32'(out_valid),
                32'(k >= 3 && k <= n_bytes + 2));
          if (out_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
              chk("extra_byte", 32'(out_data), 32'hFFFF_FFFF);
            end else begin
              chk("out_data", 32'(out_data), 32'(exp_q[0]));
              chk("out_last", 32'(out_last),
                  32'(n_xfer == n_bytes - 1));
              if (out_ready) begin
                got_q.push_back(out_data);
                void'(exp_q.pop_front());
                n_xfer++;
                if (first_k < 0) first_k = k;
                last_k = k;
                if (full_rate)
                  chk("xfer_slot", 32'(k), 32'(n_xfer + 2));
              end
            end
          end
        end
      end
      // Expectations for the next cycle
      was_active = active;
      prev_done = exp_done;
      exp_done = 0;
      exp_err = 0;
      if (reset) begin
        zero_next = 1;
        active = 0;
        exp_busy = 0;
        bc = '0;
        exp_q.delete();
      end else if (abort && active) begin
        active = 0;
        exp_busy = 0;
      end else begin
        if (active && out_valid && out_ready) begin
          bc++;
          if (n_xfer == n_bytes) begin
            active = 0;
            exp_busy = 0;
            exp_done = 1;
          end
        end
        if (start && !abort && !was_active && !prev_done) begin
          k = 0;
          done_k = -1;
          err_k = -1;
          first_k = -1;
          last_k = -1;
          n_reads = 0;
          n_xfer = 0;
          max_out = 0;
          bc = '0;
          got_q.delete();
          exp_q.delete();
          if (start_addr > end_addr) begin
            exp_done = 1;
            exp_err = 1;
          end else begin
            active = 1;
            exp_busy = 1;
            full_rate = (rdy_mode == 0);
            n_bytes = int'(end_addr) - int'(start_addr) + 1;
            rd_next = {1'b0, start_addr};
            for (logic [AW:0] a = {1'b0, start_addr};
                 a <= {1'b0, end_addr}; a++)
              exp_q.push_back(mem[a[AW-1:0]]);
          end
        end
      end
    end
  end

  task automatic pulse_start(input logic [AW-1:0] s,
                             input logic [AW-1:0] e);
    @(posedge clk);
    #1;
    start = 1'b1;
    start_addr = s;
    end_addr = e;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic pulse_abort();
    @(posedge clk);
    #1;
    abort = 1'b1;
    @(posedge clk);
    #1;
    abort = 1'b0;
  endtask

  task automatic wait_done(input int budget, input string nm);
    int c = 0;
    while (done !== 1'b1 && c < budget) begin
      @(negedge clk);
      c++;
    end
    chk({nm, "_done_seen"}, 32'(done), 1);
    @(posedge clk);
    #1;
  endtask

  logic [DW-1:0] t1_exp [4];
  logic [AW-1:0] rs;
  logic [AW-1:0] re;
  int            len;
  int            c6;

  initial begin
    reset = 1'b1;
    start = 1'b0;
    abort = 1'b0;
    start_addr = '0;
    end_addr = '0;
    t1_exp = '{8'hA0, 8'hA1, 8'hA2, 8'hA3};
    for (int i = 0; i < 4096; i++) mem[i] = DW'($urandom);
    for (int i = 0; i < 4; i++) mem[MEM_SPECIAL_BASE + i] = t1_exp[i];
    mem[12'h7FF] = 8'h5C;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // Four bytes at full rate
    rdy_mode = 0;
    pulse_start(AW'(MEM_SPECIAL_BASE), AW'(MEM_SPECIAL_BASE + 3));
    wait_done(40, "t1");
    chk("t1_first_k", 32'(first_k), 3);
    chk("t1_last_k", 32'(last_k), 6);
    chk("t1_done_k", 32'(done_k), 7);
    chk("t1_byte_count", 32'(byte_count), 4);
    chk("t1_nbytes", 32'(got_q.size()), 4);
    for (int i = 0; i < 4; i++)
      chk("t1_byte", 32'(got_q[i]), 32'(t1_exp[i]));

    // Same range, toggling ready, plus a start while busy
    rdy_mode = 1;
    pulse_start(AW'(MEM_SPECIAL_BASE), AW'(MEM_SPECIAL_BASE + 3));
    pulse_start(12'h100, 12'h105);
    wait_done(60, "t2");
    chk("t2_nbytes", 32'(got_q.size()), 4);
    for (int i = 0; i < 4; i++)
      chk("t2_byte", 32'(got_q[i]), 32'(t1_exp[i]));
    chk("t2_byte_count", 32'(byte_count), 4);

    // Sink stalled: reads stop at four outstanding
    rdy_mode = 3;
    pulse_start(12'h020, 12'h03F);
    repeat (20) @(posedge clk);
    chk("t2b_max_out", 32'(max_out), 4);
    chk("t2b_reads", 32'(n_reads), 4);
    rdy_mode = 2;
    wait_done(300, "t2b");
    chk("t2b_byte_count", 32'(byte_count), 32);

    // Single byte
    rdy_mode = 0;
    pulse_start(12'h7FF, 12'h7FF);
    wait_done(30, "t3");
    chk("t3_nbytes", 32'(got_q.size()), 1);
    chk("t3_byte", 32'(got_q[0]), 32'h5C);
    chk("t3_byte_count", 32'(byte_count), 1);

    // Top of memory, no wrap
    pulse_start(12'hFFE, 12'hFFF);
    wait_done(30, "t4");
    chk("t4_reads", 32'(n_reads), 2);
    chk("t4_busy", 32'(busy), 0);
    chk("t4_byte_count", 32'(byte_count), 2);

    // Range error
    pulse_start(12'h010, 12'h00F);
    wait_done(10, "t5");
    chk("t5_err_k", 32'(err_k), 1);
    chk("t5_done_k", 32'(done_k), 1);
    chk("t5_reads", 32'(n_reads), 0);
    chk("t5_byte_count", 32'(byte_count), 0);

    // start and abort together while idle: nothing starts
    repeat (2) @(posedge clk);
    #1;
    start = 1'b1;
    abort = 1'b1;
    start_addr = 12'h300;
    end_addr = 12'h310;
    @(posedge clk);
    #1;
    start = 1'b0;
    abort = 1'b0;
    repeat (3) @(posedge clk);
    chk("t5b_busy", 32'(busy), 0);

    // Long dump aborted after five transfers
    rdy_mode = 2;
    pulse_start(12'd8, 12'd2047);
    c6 = 0;
    while (n_xfer < 5 && c6 < 300) begin
      @(negedge clk);
      c6++;
    end
    chk("t6_progress", 32'(n_xfer >= 5), 1);
    pulse_abort();
    @(negedge clk);
    chk("t6_busy", 32'(busy), 0);
    chk("t6_valid", 32'(out_valid), 0);
    chk("t6_m_rd", 32'(m_rd), 0);
    repeat (5) @(posedge clk);
    #1;
    pulse_start(12'h040, 12'h047);
    wait_done(100, "t6b");
    chk("t6b_byte_count", 32'(byte_count), 8);

    // Reset in the middle of a dump
    pulse_start(12'h100, 12'h1FF);
    repeat (12) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    chk("t7_busy", 32'(busy), 0);
    chk("t7_valid", 32'(out_valid), 0);
    chk("t7_byte_count", 32'(byte_count), 0);
    repeat (2) @(posedge clk);
    #1;

    // Random ranges and sink patterns
    for (int it = 0; it < 10; it++) begin
      rs = AW'($urandom_range(0, 4095));
      len = $urandom_range(1, 24);
      re = (int'(rs) + len - 1 > 4095) ? 12'hFFF
                                        : AW'(int'(rs) + len - 1);
      rdy_mode = $urandom_range(0, 2);
      pulse_start(rs, re);
      wait_done(len * 8 + 40, "rnd");
      chk("rnd_byte_count", 32'(byte_count),
          32'(int'(re) - int'(rs) + 1));
    end

    repeat (3) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
